// File: rtl/video_pkg.sv
// Shared video definitions: 1280x720 timing constants, bar palette
// ({B,G,R} packing), pattern mode encodings and the bar palette lookup.
package video_pkg;

  // 1280x720p60 timing, also used by the timing generator
  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BP     = 220;
  localparam int H_TOTAL  = 1650;
  localparam int V_ACTIVE = 720;
  localparam int V_FP     = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 20;
  localparam int V_TOTAL  = 750;

  typedef logic [23:0] rgb_t;  // {B,G,R}

  localparam rgb_t WHITE   = 24'hFF_FF_FF;
  localparam rgb_t YELLOW  = 24'h00_FF_FF;
  localparam rgb_t CYAN    = 24'hFF_FF_00;
  localparam rgb_t GREEN   = 24'h00_FF_00;
  localparam rgb_t MAGENTA = 24'hFF_00_FF;
  localparam rgb_t RED     = 24'h00_00_FF;
  localparam rgb_t BLUE    = 24'hFF_00_00;
  localparam rgb_t BLACK   = 24'h00_00_00;

  typedef enum logic [1:0] {
    MODE_VBAR  = 2'd0,
    MODE_HBAR  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } tim_t;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return WHITE;
      3'd1:    return YELLOW;
      3'd2:    return CYAN;
      3'd3:    return GREEN;
      3'd4:    return MAGENTA;
      3'd5:    return RED;
      3'd6:    return BLUE;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/color_bar_gen_if.sv
// Pixel-path bundle for color_bar_gen.
//   I_mode, I_solid_rgb : pattern select and solid colour (latched per frame)
//   I_de/I_hs/I_vs      : timing from the timing generator
//   O_de/O_hs/O_vs      : timing delayed to match the pixel data
//   O_r/O_g/O_b         : generated pixel
// master = timing source / sink side, slave = the generator.
interface color_bar_gen_if;
  import video_pkg::*;

  logic [1:0] I_mode;
  rgb_t       I_solid_rgb;
  logic       I_de;
  logic       I_hs;
  logic       I_vs;
  logic       O_de;
  logic       O_hs;
  logic       O_vs;
  logic [7:0] O_r;
  logic [7:0] O_g;
  logic [7:0] O_b;

  modport master (
    output I_mode, I_solid_rgb, I_de, I_hs, I_vs,
    input  O_de, O_hs, O_vs, O_r, O_g, O_b
  );

  modport slave (
    input  I_mode, I_solid_rgb, I_de, I_hs, I_vs,
    output O_de, O_hs, O_vs, O_r, O_g, O_b
  );
endinterface

// File: rtl/video_pos_cnt.sv
// Position tracker: de/vs edge detection, saturating x/y counters and
// divider-free bar indices built from incremental sub-counters.
//   clk, rst     : pixel clock, synchronous active-high reset
//   de, vs       : raw timing inputs
//   x, y         : registered pixel position of the pixel sampled last edge
//   vbar_idx     : vertical bar index (steps every H_RES/NUM_BARS pixels)
//   hbar_idx     : horizontal bar index (steps every V_RES/NUM_BARS lines)
//   frame_start  : combinational vs rising-edge pulse (same cycle as edge)
module video_pos_cnt #(
  parameter int H_RES    = 1280,
  parameter int V_RES    = 720,
  parameter int NUM_BARS = 8,
  parameter int XW       = $clog2(H_RES),
  parameter int YW       = $clog2(V_RES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          de,
  input  logic          vs,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [2:0]    vbar_idx,
  output logic [2:0]    hbar_idx,
  output logic          frame_start
);
  localparam int BAR_W = H_RES / NUM_BARS;
  localparam int BAR_H = V_RES / NUM_BARS;
  localparam int BWW   = $clog2(BAR_W);
  localparam int BHW   = $clog2(BAR_H);

  localparam logic [XW-1:0]  X_MAX    = XW'(H_RES - 1);
  localparam logic [YW-1:0]  Y_MAX    = YW'(V_RES - 1);
  localparam logic [BWW-1:0] VSUB_MAX = BWW'(BAR_W - 1);
  localparam logic [BHW-1:0] HSUB_MAX = BHW'(BAR_H - 1);

  logic           de_q, vs_q;
  logic [BWW-1:0] vsub;
  logic [BHW-1:0] hsub;
  logic           de_fall;

  assign frame_start = vs & ~vs_q;
  assign de_fall     = ~de & de_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q     <= 1'b0;
      vs_q     <= 1'b0;
      x        <= '0;
      y        <= '0;
      vsub     <= '0;
      hsub     <= '0;
      vbar_idx <= '0;
      hbar_idx <= '0;
    end else begin
      de_q <= de;
      vs_q <= vs;

      // x is already 0 on the first de cycle (cleared while de was low),
      // so only advance while de stays high.
      if (!de) begin
        x        <= '0;
        vsub     <= '0;
        vbar_idx <= '0;
      end else if (de_q) begin
        if (x != X_MAX) x <= x + 1'b1;
        if (vsub == VSUB_MAX) begin
          vsub <= '0;
          if (vbar_idx != 3'd7) vbar_idx <= vbar_idx + 3'd1;
        end else begin
          vsub <= vsub + 1'b1;
        end
      end

      if (frame_start) begin
        y        <= '0;
        hsub     <= '0;
        hbar_idx <= '0;
      end else if (de_fall) begin
        if (y != Y_MAX) y <= y + 1'b1;
        if (hsub == HSUB_MAX) begin
          hsub <= '0;
          if (hbar_idx != 3'd7) hbar_idx <= hbar_idx + 3'd1;
        end else begin
          hsub <= hsub + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/color_bar_gen.sv
// Frame-synchronous test-pattern source between the timing generator and
// the TMDS transmitter. Two-stage pipeline: stage 1 registers timing and
// position, stage 2 looks up the colour and registers the outputs.
//   I_pxl_clk : pixel clock
//   I_rst     : synchronous active-high reset
//   bus       : color_bar_gen_if.slave (mode/solid colour, timing in/out, RGB)
module color_bar_gen
  import video_pkg::*;
#(
  parameter int H_RES      = H_ACTIVE,
  parameter int V_RES      = V_ACTIVE,
  parameter int NUM_BARS   = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic            I_pxl_clk,
  input  logic            I_rst,
  color_bar_gen_if.slave  bus
);
  localparam int XW     = $clog2(H_RES);
  localparam int YW     = $clog2(V_RES);
  localparam int STAGES = 2;

  tim_t                  tim_in;
  tim_t [STAGES:1]       tim_pipe;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [2:0]            vbar_idx, hbar_idx;
  logic                  frame_start;
  mode_e                 mode_q;
  rgb_t                  solid_q;
  rgb_t                  rgb_d, rgb_q;
  logic                  unused_pos;

  video_pos_cnt #(
    .H_RES(H_RES), .V_RES(V_RES), .NUM_BARS(NUM_BARS), .XW(XW), .YW(YW)
  ) u_pos (
    .clk(I_pxl_clk), .rst(I_rst), .de(bus.I_de), .vs(bus.I_vs),
    .x(x), .y(y), .vbar_idx(vbar_idx), .hbar_idx(hbar_idx),
    .frame_start(frame_start)
  );

  // Only the checker bit of x/y is needed here.
  assign unused_pos = ^{x, y};

  assign tim_in = '{de: bus.I_de, hs: bus.I_hs, vs: bus.I_vs};

  always_comb begin
    rgb_d = BLACK;
    if (tim_pipe[1].de) begin
      case (mode_q)
        MODE_VBAR:  rgb_d = bar_color(vbar_idx);
        MODE_HBAR:  rgb_d = bar_color(hbar_idx);
        MODE_CHECK: rgb_d = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? BLACK : WHITE;
        default:    rgb_d = solid_q;
      endcase
    end
  end

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      tim_pipe <= '0;
      mode_q   <= MODE_VBAR;
      solid_q  <= '0;
      rgb_q    <= '0;
    end else begin
      tim_pipe[1] <= tim_in;
      for (int s = 2; s <= STAGES; s++) tim_pipe[s] <= tim_pipe[s-1];
      // Pattern only changes at the vs edge (in blanking) so a frame never tears.
      if (frame_start) begin
        mode_q  <= mode_e'(bus.I_mode);
        solid_q <= bus.I_solid_rgb;
      end
      rgb_q <= rgb_d;
    end
  end

  assign bus.O_de = tim_pipe[STAGES].de;
  assign bus.O_hs = tim_pipe[STAGES].hs;
  assign bus.O_vs = tim_pipe[STAGES].vs;
  assign bus.O_r  = rgb_q[7:0];
  assign bus.O_g  = rgb_q[15:8];
  assign bus.O_b  = rgb_q[23:16];
endmodule

// File: tb/tb_color_bar_gen.sv
module tb_color_bar_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  color_bar_gen_if bus();
  color_bar_gen dut (.I_pxl_clk(clk), .I_rst(rst), .bus(bus));

  typedef struct {
    logic [26:0] v;         // {de,hs,vs,B,G,R}
    bit          spot;
    logic [23:0] spot_rgb;
    string       name;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] solid;
    int          x;
    int          y;
    logic [23:0] exp_rgb;
    string       name;
  } vec_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // reference model state
  int          mx, my;
  logic [1:0]  m_mode;
  logic [23:0] m_solid;
  logic        m_de_prev, m_vs_prev;
  logic [23:0] pal [8];

  function automatic logic [23:0] model_rgb(input logic [1:0] md, input logic [23:0] sol,
                                            input int px, input int py);
    int vb, hb;
    vb = px / 160; if (vb > 7) vb = 7;
    hb = py / 90;  if (hb > 7) hb = 7;
    case (md)
      2'd0:    return pal[vb];
      2'd1:    return pal[hb];
      2'd2:    return (((px / 32) + (py / 32)) % 2 == 1) ? 24'h000000 : 24'hFFFFFF;
      default: return sol;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // One pixel clock: drive inputs, push model expectation, then after the
  // edge compare the output against the entry for the previous input.
  task automatic step(input logic r, input logic de, input logic hs, input logic vs,
                      input bit spot = 1'b0, input logic [23:0] srgb = '0,
                      input string nm = "");
    exp_t e, z, o;
    logic [23:0] c;
    logic [26:0] got;
    z.v = '0; z.spot = 1'b0; z.spot_rgb = '0; z.name = "";
    rst = r; bus.I_de = de; bus.I_hs = hs; bus.I_vs = vs;
    if (r) begin
      q.delete();
      q.push_back(z);  // in-flight pixel is flushed by reset
      e = z;
      mx = 0; my = 0; m_mode = 2'd0; m_solid = '0; m_de_prev = 1'b0; m_vs_prev = 1'b0;
    end else begin
      if (vs && !m_vs_prev) begin
        m_mode = bus.I_mode; m_solid = bus.I_solid_rgb; my = 0;
      end else if (!de && m_de_prev) begin
        if (my < 719) my++;
      end
      if (de) begin
        mx = m_de_prev ? ((mx < 1279) ? mx + 1 : 1279) : 0;
        c  = model_rgb(m_mode, m_solid, mx, my);
      end else begin
        mx = 0; c = '0;
      end
      m_de_prev = de; m_vs_prev = vs;
      e.v = {de, hs, vs, c}; e.spot = spot; e.spot_rgb = srgb; e.name = nm;
    end
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() >= 2) begin
      o = q.pop_front();
      got = {bus.O_de, bus.O_hs, bus.O_vs, bus.O_b, bus.O_g, bus.O_r};
      checks++;
      if (got !== o.v) begin
        failures++;
        $display("FAIL pixel t=%0t got=%h exp=%h", $time, got, o.v);
      end
      if (o.spot) chk(o.name, {bus.O_de, got[23:0]}, {1'b1, o.spot_rgb});
    end
  endtask

  task automatic new_frame(input logic [1:0] md, input logic [23:0] sol);
    bus.I_mode = md; bus.I_solid_rgb = sol;  // changes in the same cycle as vs rise
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
  endtask

  task automatic skip_lines(input int n);
    for (int i = 0; i < n; i++) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
  endtask

  task automatic line(input int len, input int sx, input logic [23:0] srgb, input string nm);
    for (int i = 0; i < len; i++) step(0, 1, 0, 0, (i == sx), srgb, nm);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
  endtask

  vec_t tbl [15];

  initial begin
    pal = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
            24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
    tbl[0]  = '{2'd0, 24'h0, 0,    0,   24'hFFFFFF, "vbar_x0"};
    tbl[1]  = '{2'd0, 24'h0, 159,  0,   24'hFFFFFF, "vbar_x159"};
    tbl[2]  = '{2'd0, 24'h0, 160,  0,   24'h00FFFF, "vbar_x160"};
    tbl[3]  = '{2'd0, 24'h0, 500,  0,   24'h00FF00, "vbar_x500"};
    tbl[4]  = '{2'd0, 24'h0, 1279, 0,   24'h000000, "vbar_x1279"};
    tbl[5]  = '{2'd0, 24'h0, 1299, 0,   24'h000000, "overrun_x1299"};
    tbl[6]  = '{2'd1, 24'h0, 1279, 89,  24'hFFFFFF, "hbar_y89"};
    tbl[7]  = '{2'd1, 24'h0, 1279, 90,  24'h00FFFF, "hbar_y90"};
    tbl[8]  = '{2'd1, 24'h0, 0,    450, 24'h0000FF, "hbar_y450"};
    tbl[9]  = '{2'd1, 24'h0, 5,    719, 24'h000000, "hbar_y719"};
    tbl[10] = '{2'd2, 24'h0, 31,   0,   24'hFFFFFF, "chk_31_0"};
    tbl[11] = '{2'd2, 24'h0, 32,   0,   24'h000000, "chk_32_0"};
    tbl[12] = '{2'd2, 24'h0, 32,   32,  24'hFFFFFF, "chk_32_32"};
    tbl[13] = '{2'd2, 24'h0, 0,    32,  24'h000000, "chk_0_32"};
    tbl[14] = '{2'd3, 24'h123456, 100, 5, 24'h123456, "solid_123456"};

    bus.I_mode = 2'd0; bus.I_solid_rgb = '0;
    bus.I_de = 1'b0; bus.I_hs = 1'b0; bus.I_vs = 1'b0;

    // reset state
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk("reset_state", {5'b0, bus.O_de, bus.O_hs, bus.O_vs, bus.O_b, bus.O_g, bus.O_r}, 32'h0);
    step(0, 0, 0, 0);

    // table-driven spot points
    foreach (tbl[i]) begin
      new_frame(tbl[i].mode, tbl[i].solid);
      skip_lines(tbl[i].y);
      line(tbl[i].x + 1, tbl[i].x, tbl[i].exp_rgb, tbl[i].name);
    end

    // vertical blanking rows are black
    new_frame(2'd1, 24'h0);
    chk("vblank_rgb", {8'h0, bus.O_b, bus.O_g, bus.O_r}, 32'h0);

    // O_de latency: rises exactly 2 cycles after I_de
    new_frame(2'd0, 24'h0);
    step(0, 1, 0, 0);
    chk("de_lat_1", {31'b0, bus.O_de}, 32'd0);
    step(0, 1, 0, 0);
    chk("de_lat_2", {31'b0, bus.O_de}, 32'd1);
    step(0, 0, 0, 0); step(0, 0, 0, 0);

    // mode change mid-frame at line 300: rest of frame stays bars
    new_frame(2'd0, 24'h0);
    skip_lines(300);
    bus.I_mode = 2'd3; bus.I_solid_rgb = 24'h0000FF;
    line(1280, 200, 24'h00FFFF, "midframe_still_bars");
    new_frame(2'd3, 24'h0000FF);
    line(20, 0, 24'h0000FF, "next_frame_red");

    // reset mid-line at x=500 while in checker mode
    new_frame(2'd2, 24'h0);
    for (int i = 0; i < 500; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_midline_zero", {5'b0, bus.O_de, bus.O_hs, bus.O_vs, bus.O_b, bus.O_g, bus.O_r}, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    line(1280, 0, 24'hFFFFFF, "rst_line_x0");
    line(200, 160, 24'h00FFFF, "rst_vbar_mode");

    step(0, 0, 0, 0); step(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
